adc_channel_pack: RTL
=====================

ADC_CHANNEL_PACK -- requirements
Module: adc_channel_pack

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, number of converter channels; SHALL be a power of 2, 1..16.
REQ-002 Parameter SAMPLES_PER_CHANNEL, default 2, samples per channel per input beat.
REQ-003 Parameter SAMPLE_WIDTH, default 16, bits per sample slot.
REQ-004 Ports SHALL be, with TW = NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH:
- adc_clk  in  1  sole clock; all logic rising-edge.
- adc_rstn  in  1  asynchronous, active-low reset.
- adc_enable  in  NUM_CHANNELS  per-channel enable from core.
- adc_valid  in  NUM_CHANNELS  per-channel sample valid; bit 0 qualifies the beat.
- adc_data  in  TW  channel-major: channel c, sample s at [(c*SPC+s)*SW +: SW].
- packed_data  out  TW  packed sample stream.
- packed_valid  out  1  output word valid.
- packed_ready  in  1  downstream accept.
- packed_sof  out  1  first word after (re)start.
- adc_dovf  out  1  overflow pulse to core, one cycle per dropped word.
- cfg_err  out  1  enable mask not a power-of-2 count.

Function
REQ-005 N = popcount(adc_enable) SHALL be sampled each cycle; legal N is 1, 2, 4, ..., NUM_CHANNELS.
REQ-006 For N = 0 or N not a power of 2, cfg_err SHALL be 1, input beats SHALL be ignored, nothing SHALL be written to the output buffer.
REQ-007 Each valid beat SHALL contribute N*SPC samples, sample-major in ascending channel index: s0 of every enabled channel, then s1, ...
REQ-008 Beats SHALL be accumulated into TW from the LSB; word complete after R = NUM_CHANNELS/N beats (R=1 means pass-through with reordering only).
REQ-009 Beat counter SHALL count 0..R-1 and wrap to 0 on the completing beat.
REQ-010 A completed word SHALL be written to the output buffer on the clock edge after the completing beat (latency 1 cycle to packed_valid when the buffer is empty).
REQ-011 Any change of adc_enable between cycles SHALL discard the partial word, clear the beat counter, and arm packed_sof; the beat presented in the change cycle SHALL use the new mask as beat 0.
REQ-012 Output buffer SHALL be a 2-entry FIFO; packed_data/packed_valid/packed_sof SHALL come from the head entry, registered.
REQ-013 Transfer occurs when packed_valid and packed_ready are both 1; packed_data and packed_sof SHALL hold stable while packed_valid=1 and packed_ready=0.
REQ-014 packed_sof SHALL be 1 only on the first word stored after reset or an armed restart; the arm SHALL clear when that word is stored.
REQ-015 Write and read in the same cycle with FIFO full SHALL both succeed (no drop).
REQ-016 Completed word with FIFO full and no read in that cycle SHALL be dropped and adc_dovf SHALL pulse high for exactly one cycle; FIFO content unchanged; a dropped sof-word SHALL keep the arm set.
REQ-017 packed_ready SHALL have no combinational path to any output.

Reset
REQ-018 While adc_rstn=0: packed_valid=0, packed_sof=0, adc_dovf=0, cfg_err=0, packed_data=0, FIFO empty, beat counter 0, sof armed.
REQ-019 Reset assertion mid-word or mid-transfer SHALL discard all buffered data immediately; first valid beat after deassertion is beat 0.

Verification
REQ-020 NUM_CHANNELS=4, SPC=2, SW=16, enable=4'b1111, ready=1, beat data 0x0007_0006_..._0000 -> next cycle packed_valid=1, sof=1, packed_data slots = 0,2,4,6,1,3,5,7 (ch0s0,ch1s0,ch2s0,ch3s0,ch0s1,...).
REQ-021 enable=4'b0101, 2 beats of ch0={A0,A1}, ch2={C0,C1} -> one word, slots A0,C0,A1,C1 (beat 1) then next beat in upper half; packed_valid only after second beat.
REQ-022 enable=4'b0111 -> cfg_err=1, no packed_valid for 10 valid beats; enable back to 4'b0001 -> cfg_err=0, first word after 4 beats carries sof=1.
REQ-023 enable=4'b1111, ready=0, 3 consecutive beats -> words 1,2 held, adc_dovf single-cycle pulse on 3rd; ready=1 -> words 1,2 emitted in order, unchanged.
REQ-024 enable=4'b0001, 2 of 4 beats received, then enable=4'b0011 -> partial discarded; next word forms after 2 new beats, sof=1.
REQ-025 Assert adc_rstn=0 asynchronously with FIFO holding 2 words -> packed_valid=0 same cycle; after release, first word has sof=1.

Source files
------------

// File: rtl/adc_channel_pack.sv
// rtl/adc_channel_pack.sv - ADC per-channel sample packer with 2-entry output queue

module adc_pack_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             rd;
    logic             wr;

    // Head entry is the output register itself; a full queue still accepts when it is read this cycle.
    assign m_tvalid = (count_q != 2'd0);
    assign rd       = m_tvalid && m_tready;
    assign s_tready = (count_q != 2'd2) || rd;
    assign wr       = s_tvalid && s_tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tdata <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({wr, rd})
                2'b10: begin
                    if (count_q == 2'd0) m_tdata <= s_tdata;
                    else                 tail_q  <= s_tdata;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) m_tdata <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        m_tdata <= s_tdata;
                    end else begin
                        m_tdata <= tail_q;
                        tail_q  <= s_tdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module adc_channel_pack #(
    parameter int NUM_CHANNELS        = 4,
    parameter int SAMPLES_PER_CHANNEL = 2,
    parameter int SAMPLE_WIDTH        = 16,
    localparam int TW = NUM_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_WIDTH
) (
    input  logic                    adc_clk,
    input  logic                    adc_rstn,
    input  logic [NUM_CHANNELS-1:0] adc_enable,
    input  logic [NUM_CHANNELS-1:0] adc_valid,
    input  logic [TW-1:0]           adc_data,
    output logic [TW-1:0]           packed_data,
    output logic                    packed_valid,
    input  logic                    packed_ready,
    output logic                    packed_sof,
    output logic                    adc_dovf,
    output logic                    cfg_err
);
    localparam int SPC = SAMPLES_PER_CHANNEL;
    localparam int SW  = SAMPLE_WIDTH;
    localparam int CW  = $clog2(NUM_CHANNELS + 1);
    localparam int BW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0] enable_q;
    logic [BW-1:0]           beat_q;
    logic [BW-1:0]           beat_idx;
    logic [TW-1:0]           acc_q;
    logic [TW-1:0]           acc_next;
    logic [CW-1:0]           n_en;
    logic                    sof_arm_q;
    logic                    sof_now;
    logic                    legal;
    logic                    changed;
    logic                    beat;
    logic                    complete;
    logic                    fifo_ready;
    logic                    head_sof;
    logic                    unused_valid;

    assign unused_valid = ^adc_valid;

    always_comb begin
        n_en = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) n_en = n_en + CW'(adc_enable[c]);
    end

    assign legal    = (n_en != '0) && ((n_en & (n_en - 1'b1)) == '0);
    assign changed  = (adc_enable != enable_q);
    assign beat     = adc_valid[0] && legal;
    assign beat_idx = changed ? '0 : beat_q;
    assign complete = beat && ((int'(beat_idx) + 1) * int'(n_en) == NUM_CHANNELS);
    assign sof_now  = sof_arm_q || changed;

    // Sample-major gather: slot = beat offset + s*N + rank of the channel among enabled ones.
    always_comb begin
        int rank;
        int base;
        acc_next = changed ? '0 : acc_q;
        rank     = 0;
        base     = int'(beat_idx) * int'(n_en) * SPC;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (adc_enable[c]) begin
                for (int s = 0; s < SPC; s++) begin
                    acc_next[(base + s * int'(n_en) + rank) * SW +: SW] = adc_data[(c * SPC + s) * SW +: SW];
                end
                rank = rank + 1;
            end
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            enable_q  <= '0;
            beat_q    <= '0;
            acc_q     <= '0;
            sof_arm_q <= 1'b1;
            adc_dovf  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            enable_q <= adc_enable;
            cfg_err  <= !legal;
            adc_dovf <= complete && !fifo_ready;
            if (beat) begin
                acc_q  <= acc_next;
                beat_q <= complete ? '0 : beat_idx + 1'b1;
            end else if (changed) begin
                acc_q  <= '0;
                beat_q <= '0;
            end
            // A dropped start-of-frame word leaves the arm set for the next stored word.
            if (complete && fifo_ready) sof_arm_q <= 1'b0;
            else if (changed)           sof_arm_q <= 1'b1;
        end
    end

    adc_pack_fifo #(
        .WIDTH(TW + 1)
    ) u_out_fifo (
        .clk      (adc_clk),
        .resetn   (adc_rstn),
        .s_tdata  ({sof_now, acc_next}),
        .s_tvalid (complete),
        .s_tready (fifo_ready),
        .m_tdata  ({head_sof, packed_data}),
        .m_tvalid (packed_valid),
        .m_tready (packed_ready)
    );

    assign packed_sof = head_sof && packed_valid;
endmodule
